// File: rtl/rv32i_lsu_bus_pkg.sv
// Shared types and constants for the RV32I load/store bus unit.
//   lsu_state_e  : FSM state encodings (3-bit)
//   lsu_req_t    : request captured from the ALU on accept
//   LSU_*_DEFAULT: default parameter values for the top level
package rv32i_lsu_bus_pkg;

  typedef enum logic [2:0] {
    LSU_IDLE   = 3'd0,
    LSU_WRITE  = 3'd1,
    LSU_RDCMD  = 3'd2,
    LSU_RDDATA = 3'd3,
    LSU_RESP   = 3'd4
  } lsu_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } lsu_req_t;

  localparam int          LSU_TIMEOUT_DEFAULT   = 255;
  localparam logic [31:0] LSU_ERR_RDATA_DEFAULT = 32'h0000_0000;

  // States in which a bus access is outstanding and the timeout runs.
  function automatic logic lsu_is_bus(input lsu_state_e s);
    return (s == LSU_WRITE) || (s == LSU_RDCMD) || (s == LSU_RDDATA);
  endfunction

endpackage

// File: rtl/rv32i_lsu_timeout.sv
// Bus access timeout: down-counter loaded on clear, decremented while
// enabled, flags expiry on the TIMEOUT_CYCLES-th enabled cycle.
//   clk, reset_n : clock, synchronous active-low reset
//   clear        : reload the counter (asserted on every state change)
//   enable       : count this cycle (an access is outstanding)
//   expired      : combinational, high in the last allowed cycle
// TIMEOUT_CYCLES = 0 disables the timeout entirely.
module rv32i_lsu_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_tmo;
      assign unused_tmo = &{1'b0, clk, reset_n, clear, enable};
      assign expired    = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
      logic [CW-1:0] cnt;

      always_ff @(posedge clk) begin
        if (!reset_n)
          cnt <= '0;
        else if (clear)
          cnt <= CW'(TIMEOUT_CYCLES);
        else if (enable && cnt != '0)
          cnt <= cnt - CW'(1);
      end

      // Counter holds TIMEOUT_CYCLES in the first cycle after entry, so it
      // reads 1 in the TIMEOUT_CYCLES-th cycle spent in the state.
      assign expired = enable && (cnt == CW'(1));
    end
  endgenerate

endmodule

// File: rtl/rv32i_lsu_bus.sv
// Load/store bus unit downstream of the RV32I ALU. Captures one load or
// store request and runs it as a single pipelined Avalon-MM transfer,
// stalling the ALU until the write is accepted or read data returns.
//   clk, reset_n        : clock, synchronous active-low reset
//   load, store, addr,
//   st_be, wr_data      : request from the ALU (load is a held level)
//   stall               : combinational ALU hold
//   ld_data             : registered, unaligned load word
//   clr_load_op         : cancels the ALU's pending load after an abort
//   bus_err             : one-cycle pulse on timeout abort
//   avm_*               : Avalon-MM data master (all outputs registered)
module rv32i_lsu_bus
  import rv32i_lsu_bus_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT,
  parameter logic [31:0] ERR_RDATA      = LSU_ERR_RDATA_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        store,
  input  logic [31:0] addr,
  input  logic [3:0]  st_be,
  input  logic [31:0] wr_data,
  output logic        stall,
  output logic [31:0] ld_data,
  output logic        clr_load_op,
  output logic        bus_err,
  output logic [31:0] avm_address,
  output logic [3:0]  avm_byteenable,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid
);

  lsu_state_e state_q, state_d;
  lsu_req_t   req;
  logic       load_eff;
  logic       accept;
  logic       tmo_clear, tmo_en, tmo_expired;

  rv32i_lsu_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (tmo_clear),
    .enable (tmo_en),
    .expired(tmo_expired)
  );

  assign tmo_en    = lsu_is_bus(state_q);
  assign tmo_clear = (state_d != state_q);

  always_comb begin
    // The ALU's load flag is still up in the RESP cycle that follows an
    // aborted load; it is being cancelled, so it is not a new request.
    load_eff = load & ~clr_load_op;
    req.addr = addr & 32'hFFFF_FFFC;
    req.be   = load_eff ? 4'hF : st_be;
    req.data = wr_data;
    state_d  = state_q;
    accept   = 1'b0;
    stall    = 1'b0;
    unique case (state_q)
      LSU_IDLE, LSU_RESP: begin
        stall = load_eff | store;
        // load wins if both arrive; the store is dropped
        if (load_eff) begin
          state_d = LSU_RDCMD;
          accept  = 1'b1;
        end else if (store) begin
          state_d = LSU_WRITE;
          accept  = 1'b1;
        end else begin
          state_d = LSU_IDLE;
        end
      end
      LSU_WRITE: begin
        stall = avm_waitrequest;
        if (tmo_expired)           state_d = LSU_RESP;
        else if (!avm_waitrequest) state_d = LSU_IDLE;
      end
      LSU_RDCMD: begin
        stall = 1'b1;
        if (tmo_expired)           state_d = LSU_RESP;
        else if (!avm_waitrequest) state_d = LSU_RDDATA;
      end
      LSU_RDDATA: begin
        stall = 1'b1;
        if (tmo_expired)            state_d = LSU_RESP;
        else if (avm_readdatavalid) state_d = LSU_RESP;
      end
      default: state_d = LSU_IDLE;
    endcase
    if (!reset_n) stall = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= LSU_IDLE;
      avm_write      <= 1'b0;
      avm_read       <= 1'b0;
      avm_address    <= '0;
      avm_byteenable <= '0;
      avm_writedata  <= '0;
      ld_data        <= '0;
      bus_err        <= 1'b0;
      clr_load_op    <= 1'b0;
    end else begin
      state_q <= state_d;
      // Commands follow the next state so they drop on abort or accept.
      avm_write <= (state_d == LSU_WRITE);
      avm_read  <= (state_d == LSU_RDCMD);
      bus_err     <= tmo_expired;
      clr_load_op <= tmo_expired &&
                     (state_q == LSU_RDCMD || state_q == LSU_RDDATA);
      if (accept) begin
        avm_address    <= req.addr;
        avm_byteenable <= req.be;
        if (!load_eff) avm_writedata <= req.data;
      end
      if (tmo_expired)
        ld_data <= ERR_RDATA;
      else if (state_q == LSU_RDDATA && avm_readdatavalid)
        ld_data <= avm_readdata;
    end
  end

endmodule

// File: tb/tb_rv32i_lsu_bus.sv
// Directed and randomised-slave checks for rv32i_lsu_bus (TIMEOUT_CYCLES=8).
module tb_rv32i_lsu_bus;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load, store;
  logic [31:0] addr, wr_data;
  logic [3:0]  st_be;
  logic        stall, clr_load_op, bus_err;
  logic [31:0] ld_data, avm_address, avm_writedata, avm_readdata;
  logic [3:0]  avm_byteenable;
  logic        avm_write, avm_read, avm_waitrequest, avm_readdatavalid;

  // directed drive vs random slave drive
  logic        slave_en;
  logic        d_wait, d_rdv;
  logic [31:0] d_rdata;
  logic        s_wait, s_rdv;
  logic [31:0] s_rdata;

  int n_chk = 0;
  int n_fail = 0;

  assign avm_waitrequest   = slave_en ? s_wait  : d_wait;
  assign avm_readdatavalid = slave_en ? s_rdv   : d_rdv;
  assign avm_readdata      = slave_en ? s_rdata : d_rdata;

  always #5 clk = ~clk;

  rv32i_lsu_bus #(.TIMEOUT_CYCLES(8), .ERR_RDATA(32'h0000_0000)) dut (
    .clk(clk), .reset_n(reset_n), .load(load), .store(store), .addr(addr),
    .st_be(st_be), .wr_data(wr_data), .stall(stall), .ld_data(ld_data),
    .clr_load_op(clr_load_op), .bus_err(bus_err),
    .avm_address(avm_address), .avm_byteenable(avm_byteenable),
    .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_read(avm_read), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] init_word(input int i);
    return 32'hA5A5_0000 + 32'(i) * 32'h0001_0101;
  endfunction

  always @(negedge clk)
    assert (!(reset_n === 1'b1 && load === 1'b1 && store === 1'b1))
      else $error("protocol violation: load and store together");

  // Random Avalon slave with a small word memory
  logic [31:0] smem [8];
  initial begin
    bit       pend = 0, in_cmd = 0;
    int       pend_cnt = 0, wleft = 0;
    logic [31:0] pend_data = '0;
    for (int i = 0; i < 8; i++) smem[i] = init_word(i);
    s_wait = 1'b0; s_rdv = 1'b0; s_rdata = '0;
    forever begin
      @(negedge clk);
      if (slave_en) begin
        if (avm_write && !avm_waitrequest)
          for (int b = 0; b < 4; b++)
            if (avm_byteenable[b]) smem[avm_address[4:2]][8*b +: 8] = avm_writedata[8*b +: 8];
        if (avm_read && !avm_waitrequest) begin
          pend = 1; pend_cnt = int'($urandom_range(1, 4)); pend_data = smem[avm_address[4:2]];
        end
        if ((avm_read || avm_write) && !avm_waitrequest) in_cmd = 0;
      end
      step();
      if (slave_en) begin
        s_rdv = 1'b0; s_rdata = $urandom;
        if (pend) begin
          if (pend_cnt == 1) begin s_rdv = 1'b1; s_rdata = pend_data; pend = 0; end
          else pend_cnt--;
        end
        if (avm_read || avm_write) begin
          if (!in_cmd) begin in_cmd = 1; wleft = int'($urandom_range(0, 3)); end
          s_wait = (wleft != 0);
          if (wleft != 0) wleft--;
        end else begin
          s_wait = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // Commands must not change while stalled by waitrequest
  logic        mon_hold = 1'b0;
  logic [31:0] p_addr, p_wd;
  logic [5:0]  p_ctl;
  always @(negedge clk) begin
    if (slave_en && mon_hold) begin
      chk("hold_addr", avm_address, p_addr);
      chk("hold_ctl", 32'({avm_read, avm_write, avm_byteenable}), 32'(p_ctl));
      chk("hold_wdata", avm_writedata, p_wd);
    end
    mon_hold = (avm_read || avm_write) && avm_waitrequest;
    p_addr = avm_address; p_wd = avm_writedata;
    p_ctl = {avm_read, avm_write, avm_byteenable};
  end

  logic [31:0] ref_mem [8];

  task automatic do_op(input bit is_ld, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    int n = 0;
    logic [2:0] w;
    w = a[4:2];
    load = is_ld; store = !is_ld; addr = a; st_be = be; wr_data = d;
    if (!is_ld)
      for (int b = 0; b < 4; b++) if (be[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
    @(negedge clk);
    chk("op_stall_start", 32'(stall), 1);
    step();
    load = 0; store = 0;
    @(negedge clk);
    while (stall && n < 40) begin step(); @(negedge clk); n++; end
    chk("op_done", 32'(n < 40), 1);
    if (is_ld) chk("op_ld_data", ld_data, ref_mem[w]);
    chk("op_bus_err", 32'(bus_err), 0);
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stall_n, rd_n, wr_n, err_n;
    logic [7:0] wq_t, rdv_t;
    slave_en = 0; d_wait = 0; d_rdv = 0; d_rdata = '0;
    reset_n = 0; load = 1; store = 0; addr = '0; st_be = '0; wr_data = '0;
    step(); step(); step();
    @(negedge clk);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_cmd", 32'({avm_read, avm_write}), 0);
    chk("rst_addr", avm_address, 0);
    chk("rst_ld_data", ld_data, 0);
    chk("rst_pulses", 32'({bus_err, clr_load_op}), 0);
    step();
    load = 0; reset_n = 1;
    step();

    // Zero-wait store
    store = 1; addr = 32'h0000_1004; st_be = 4'b1100; wr_data = 32'hABCD_0000;
    @(negedge clk);
    chk("st_c0_stall", 32'(stall), 1);
    chk("st_c0_write", 32'(avm_write), 0);
    step(); store = 0;
    @(negedge clk);
    chk("st_c1_write", 32'(avm_write), 1);
    chk("st_c1_addr", avm_address, 32'h0000_1004);
    chk("st_c1_be", 32'(avm_byteenable), 32'hC);
    chk("st_c1_wdata", avm_writedata, 32'hABCD_0000);
    chk("st_c1_stall", 32'(stall), 0);
    step();
    @(negedge clk);
    chk("st_c2_write", 32'(avm_write), 0);
    chk("st_c2_stall", 32'(stall), 0);
    step();

    // Load, 2 wait cycles, data 3 cycles after accept; low addr bits ignored
    wq_t = 8'b0000_0110; rdv_t = 8'b0100_0000; stall_n = 0; rd_n = 0;
    for (int k = 0; k < 8; k++) begin
      load = (k == 0); addr = 32'h0000_2003;
      d_wait = wq_t[k]; d_rdv = rdv_t[k];
      d_rdata = rdv_t[k] ? 32'h1234_5678 : 32'hBAD0_BAD0;
      @(negedge clk);
      if (stall) stall_n++;
      if (avm_read) rd_n++;
      if (k == 1) begin
        chk("ld_addr", avm_address, 32'h0000_2000);
        chk("ld_be", 32'(avm_byteenable), 32'hF);
      end
      if (k == 7) begin
        chk("ld_resp_data", ld_data, 32'h1234_5678);
        chk("ld_resp_stall", 32'(stall), 0);
      end
      step();
    end
    d_rdv = 0; d_wait = 0;
    chk("ld_stall_cycles", stall_n, 7);
    chk("ld_read_cycles", rd_n, 3);
    @(negedge clk);
    chk("ld_data_held", ld_data, 32'h1234_5678);
    step();

    // Reset during READ_DATA
    load = 1; addr = 32'h0000_2040;
    @(negedge clk); step(); load = 0;
    @(negedge clk); step();
    reset_n = 0;
    @(negedge clk); step();
    reset_n = 1;
    @(negedge clk);
    chk("rstrd_read", 32'(avm_read), 0);
    chk("rstrd_stall", 32'(stall), 0);
    chk("rstrd_ld_data", ld_data, 0);
    chk("rstrd_addr", avm_address, 0);
    step();
    d_rdv = 1; d_rdata = 32'h7777_7777;   // orphan valid from the abandoned read
    @(negedge clk); step();
    d_rdv = 0;
    store = 1; addr = 32'h0000_1010; st_be = 4'hF; wr_data = 32'h600D_F00D;
    @(negedge clk);
    chk("rstrd_st_stall", 32'(stall), 1);
    step(); store = 0;
    @(negedge clk);
    chk("rstrd_st_write", 32'(avm_write), 1);
    chk("rstrd_st_addr", avm_address, 32'h0000_1010);
    chk("rstrd_ld_kept", ld_data, 0);
    step();
    @(negedge clk);
    chk("rstrd_st_done", 32'({avm_write, stall}), 0);
    step();

    // Reset while a read command is held by waitrequest
    load = 1; addr = 32'h0000_2080; d_wait = 1;
    @(negedge clk); step(); load = 0;
    @(negedge clk);
    chk("rstcmd_read_pre", 32'(avm_read), 1);
    step(); reset_n = 0;
    @(negedge clk); step();
    reset_n = 1; d_wait = 0;
    @(negedge clk);
    chk("rstcmd_read", 32'(avm_read), 0);
    chk("rstcmd_stall", 32'(stall), 0);
    step();

    // Back-to-back: store arrives in RESP of a zero-wait load
    load = 1; addr = 32'h0000_3000;
    @(negedge clk);
    chk("b2b_c0_stall", 32'(stall), 1);
    step(); load = 0;
    @(negedge clk); step();
    d_rdv = 1; d_rdata = 32'hCAFE_F00D;
    @(negedge clk); step();
    d_rdv = 0;
    store = 1; addr = 32'h0000_3008; st_be = 4'b0011; wr_data = 32'h0000_0055;
    @(negedge clk);
    chk("b2b_resp_data", ld_data, 32'hCAFE_F00D);
    chk("b2b_resp_stall", 32'(stall), 1);
    step(); store = 0;
    @(negedge clk);
    chk("b2b_write", 32'(avm_write), 1);
    chk("b2b_addr", avm_address, 32'h0000_3008);
    chk("b2b_be", 32'(avm_byteenable), 32'h3);
    chk("b2b_wdata", avm_writedata, 32'h0000_0055);
    step();
    @(negedge clk);
    chk("b2b_done", 32'(avm_write), 0);
    step();

    // Load timeout: readdatavalid never comes; load held until cancelled
    load = 1; addr = 32'h0000_4000;
    @(negedge clk); step();
    @(negedge clk); step();
    err_n = 0; stall_n = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus_err) err_n++;
      if (stall) stall_n++;
      step();
    end
    chk("tmo_ld_no_early_err", err_n, 0);
    chk("tmo_ld_stall", stall_n, 8);
    @(negedge clk);
    chk("tmo_ld_bus_err", 32'(bus_err), 1);
    chk("tmo_ld_clr", 32'(clr_load_op), 1);
    chk("tmo_ld_data", ld_data, 0);
    chk("tmo_ld_stall_resp", 32'(stall), 0);
    step();
    load = 0; d_rdv = 1; d_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("tmo_ld_pulse_end", 32'({bus_err, clr_load_op}), 0);
    step();
    d_rdv = 0;
    @(negedge clk);
    chk("tmo_ld_late_valid", ld_data, 0);
    chk("tmo_ld_idle", 32'({avm_read, stall}), 0);
    step();

    // Store timeout: waitrequest stuck high
    store = 1; addr = 32'h0000_5000; st_be = 4'hF; wr_data = 32'h1111_2222; d_wait = 1;
    @(negedge clk); step(); store = 0;
    wr_n = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (avm_write) wr_n++;
      step();
    end
    chk("tmo_st_write_cycles", wr_n, 8);
    @(negedge clk);
    chk("tmo_st_bus_err", 32'(bus_err), 1);
    chk("tmo_st_clr", 32'(clr_load_op), 0);
    chk("tmo_st_write", 32'(avm_write), 0);
    chk("tmo_st_stall", 32'(stall), 0);
    step();
    d_wait = 0;
    step();

    // Random-latency sweep against a reference memory
    for (int i = 0; i < 8; i++) ref_mem[i] = init_word(i);
    slave_en = 1;
    step();
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = 32'h0000_0100 + 32'($urandom_range(0, 7)) * 32'd4 + 32'($urandom_range(0, 3));
      do_op(($urandom_range(0, 1) == 1), a, 4'($urandom_range(1, 15)), $urandom);
    end
    slave_en = 0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
